// File: rtl/noc_io_pkg.sv
// -----------------------------------------------------------------------------
// noc_io_pkg
// Shared constants and helpers for the board-input front-end of the noc.
//   DEFAULT_DEBOUNCE_COUNT : 25 ms of stable input at 50 MHz
//   SIM_DEBOUNCE_COUNT     : short debounce window so simulations stay quick
//   deb_action_e           : the four things a debounce channel can do per cycle
//   deb_action()           : priority decode of those actions
// -----------------------------------------------------------------------------
package noc_io_pkg;

  localparam int DEFAULT_DEBOUNCE_COUNT = 1250000;
  localparam int SIM_DEBOUNCE_COUNT     = 4;

  // Per-cycle decision of a debounce channel, highest priority first.
  typedef enum logic [1:0] {
    DEB_RESTART = 2'd0,  // synchronised input moved: adopt it as new candidate
    DEB_IDLE    = 2'd1,  // candidate already equals the output: nothing to do
    DEB_COMMIT  = 2'd2,  // candidate held long enough: publish it
    DEB_COUNT   = 2'd3   // candidate still proving itself: keep counting
  } deb_action_e;

  function automatic deb_action_e deb_action(
    input logic sample_differs,
    input logic settled,
    input logic at_terminal
  );
    deb_action_e act;
    if (sample_differs) begin
      act = DEB_RESTART;
    end else if (settled) begin
      act = DEB_IDLE;
    end else if (at_terminal) begin
      act = DEB_COMMIT;
    end else begin
      act = DEB_COUNT;
    end
    return act;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Two-flop synchroniser followed by a debouncer for a WIDTH-bit group of raw
// inputs that share one stability counter. The output only moves once the
// synchronised value has been steady for DEBOUNCE_COUNT consecutive cycles
// after being captured as candidate; any movement restarts the count.
//
// Ports:
//   clk     : clock
//   srst    : synchronous active-high reset, clears every register
//   raw     : asynchronous raw input levels
//   stable  : debounced output, all bits update on the same edge
//   changed : one-cycle pulse, high in the first cycle stable shows a new value
// -----------------------------------------------------------------------------
module debounce_channel
  import noc_io_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
  parameter int CNT_WIDTH      = $clog2(DEBOUNCE_COUNT + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  if (DEBOUNCE_COUNT < 1) begin : g_bad_count
    $error("debounce_channel: DEBOUNCE_COUNT must be at least 1");
  end

  // Last value the counter reaches; the counter therefore never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

  logic [WIDTH-1:0]     s1_reg;
  logic [WIDTH-1:0]     s2_reg;
  logic [WIDTH-1:0]     cand_reg;
  logic [WIDTH-1:0]     cand_next;
  logic [WIDTH-1:0]     stable_reg;
  logic [WIDTH-1:0]     stable_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 changed_reg;
  logic                 changed_next;
  deb_action_e          action;

  // Synchroniser: s1 may be metastable and is read only by s2.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

  always_comb begin
    action       = deb_action(s2_reg != cand_reg,
                              cand_reg == stable_reg,
                              cnt_reg == CNT_LAST);
    cand_next    = cand_reg;
    stable_next  = stable_reg;
    cnt_next     = cnt_reg;
    changed_next = 1'b0;
    case (action)
      DEB_RESTART: begin
        cand_next = s2_reg;
        cnt_next  = '0;
      end
      DEB_IDLE: begin
        // Also abandons a count when the input bounced back to the old value.
        cnt_next = '0;
      end
      DEB_COMMIT: begin
        stable_next  = cand_reg;
        cnt_next     = '0;
        changed_next = 1'b1;
      end
      default: begin
        cnt_next = cnt_reg + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cand_reg    <= '0;
      stable_reg  <= '0;
      cnt_reg     <= '0;
      changed_reg <= 1'b0;
    end else begin
      cand_reg    <= cand_next;
      stable_reg  <= stable_next;
      cnt_reg     <= cnt_next;
      changed_reg <= changed_next;
    end
  end

  assign stable  = stable_reg;
  assign changed = changed_reg;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Front-end between raw board keys/switches and the noc core. Every button is
// its own debounce channel; the switch vector is one channel with a shared
// counter so the whole vector updates atomically.
//
// Ports:
//   Clock           : system clock
//   Reset           : synchronous active-high reset
//   ButtonsRaw      : raw button levels, 1 = pressed (already active-high)
//   SwitchesRaw     : raw switch levels
//   Buttons         : debounced button levels
//   ButtonPress     : one-cycle pulse per debounced button press (not release)
//   Switches        : debounced switch vector
//   SwitchesChanged : one-cycle pulse when Switches takes a new value
// -----------------------------------------------------------------------------
module input_conditioner
  import noc_io_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT,
  parameter int N_BUTTONS      = 2,
  parameter int SW_WIDTH       = 32,
  parameter int CNT_WIDTH      = $clog2(DEBOUNCE_COUNT + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N_BUTTONS-1:0] ButtonsRaw,
  input  logic [SW_WIDTH-1:0]  SwitchesRaw,
  output logic [N_BUTTONS-1:0] Buttons,
  output logic [N_BUTTONS-1:0] ButtonPress,
  output logic [SW_WIDTH-1:0]  Switches,
  output logic                 SwitchesChanged
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_button
      logic btn_stable;
      logic btn_changed;

      debounce_channel #(
        .WIDTH          (1),
        .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
        .CNT_WIDTH      (CNT_WIDTH)
      ) u_btn (
        .clk     (Clock),
        .srst    (Reset),
        .raw     (ButtonsRaw[gi]),
        .stable  (btn_stable),
        .changed (btn_changed)
      );

      assign Buttons[gi]     = btn_stable;
      // Change pulse and level are both registered; a change to 1 is a press.
      assign ButtonPress[gi] = btn_changed & btn_stable;
    end
  endgenerate

  debounce_channel #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_switches (
    .clk     (Clock),
    .srst    (Reset),
    .raw     (SwitchesRaw),
    .stable  (Switches),
    .changed (SwitchesChanged)
  );

endmodule
